// File: rtl/serial_to_parallel_1101.sv
// Serial receiver: hunts for a sliding 4-bit sync pattern, then assembles the
// next DATA_W bits MSB-first and offers the word through a valid/ack handshake.
module serial_to_parallel_1101 #(
  parameter int          DATA_W   = 8,
  parameter logic [3:0]  SYNC_PAT = 4'b1101,
  parameter int          CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bit_en,
  input  logic              din,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              sync_det,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BW = $clog2(DATA_W);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t state, state_next;

  // Only the three most recent bits need storing; the fourth comes from din.
  logic [2:0]        window;
  logic [DATA_W-2:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic              strobe;
  logic              sync_hit;
  logic              word_done;
  logic [DATA_W-1:0] word;

  always_comb begin
    state_next = state;
    sync_hit   = 1'b0;
    word_done  = 1'b0;
    strobe     = en & bit_en;
    word       = {shift, din};
    if (!en) begin
      state_next = HUNT;
    end else if (strobe) begin
      case (state)
        HUNT: begin
          if ({window, din} == SYNC_PAT) begin
            sync_hit   = 1'b1;
            state_next = RECV;
          end
        end
        RECV: begin
          if (bit_cnt == BW'(DATA_W - 1)) begin
            word_done  = 1'b1;
            state_next = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window     <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sync_det   <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      sync_det <= sync_hit;
      if (!en) begin
        window  <= '0;
        shift   <= '0;
        bit_cnt <= '0;
      end else if (strobe) begin
        if (state == HUNT) begin
          window  <= {window[1:0], din};
          bit_cnt <= '0;
        end else if (word_done) begin
          window  <= '0;
          shift   <= '0;
          bit_cnt <= '0;
        end else begin
          shift   <= word[DATA_W-2:0];
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // A completing word always wins over a same-cycle ack.
      if (word_done) begin
        data_out   <= word;
        data_valid <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
        if (data_valid && !data_ack) overrun <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_serial_to_parallel_1101.sv
// Directed testbench for serial_to_parallel_1101: framing, sliding sync,
// handshake/overrun, abort, strobe gating, async reset and counter wrap.
module tb_serial_to_parallel_1101;

  logic       clk;
  logic       rst;
  logic       en;
  logic       bit_en;
  logic       din;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sync_det;
  logic       busy;
  logic       overrun;
  logic [7:0] frame_cnt;

  int errors;
  int checks;

  serial_to_parallel_1101 dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bit_en     (bit_en),
    .din        (din),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sync_det   (sync_det),
    .busy       (busy),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge, after the strobe was sampled.
  task automatic send_bit(input logic b, input logic ack);
    din      = b;
    bit_en   = 1'b1;
    data_ack = ack;
    @(negedge clk);
    bit_en   = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic ack_last);
    logic [3:0] sp;
    sp = 4'b1101;
    for (int i = 3; i >= 0; i--) send_bit(sp[i], 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    send_bit(w[0], ack_last);
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({data_out, data_valid, sync_det, busy, overrun, frame_cnt} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got out=%h v=%b s=%b b=%b o=%b cnt=%0d, want all zero",
               data_out, data_valid, sync_det, busy, overrun, frame_cnt);
    end
  endtask

  task automatic test_basic();
    logic [4:0] pre;
    logic [7:0] pay;
    pre = 5'b01101;
    pay = 8'hA5;
    en  = 1'b1;
    for (int i = 4; i >= 1; i--) send_bit(pre[i], 1'b0);
    checks++;
    if (sync_det !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early_sync: got sync=%b busy=%b, want 0 0", sync_det, busy);
    end
    send_bit(pre[0], 1'b0);
    checks++;
    if (sync_det !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_sync_pulse: got sync=%b busy=%b, want 1 1", sync_det, busy);
    end
    for (int i = 7; i >= 1; i--) send_bit(pay[i], 1'b0);
    checks++;
    if (sync_det !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_mid_frame: got sync=%b valid=%b, want 0 0", sync_det, data_valid);
    end
    send_bit(pay[0], 1'b0);
    checks++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1 || frame_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_word: got out=%h v=%b cnt=%0d busy=%b, want a5 1 1 0",
               data_out, data_valid, frame_cnt, busy);
    end
    pulse_ack();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_ack: got valid=%b, want 0", data_valid);
    end
    pulse_ack();
    checks++;
    if (data_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ack: got valid=%b overrun=%b, want 0 0", data_valid, overrun);
    end
  endtask

  task automatic test_sliding_sync();
    logic [4:0] pre;
    logic [7:0] pay;
    pre = 5'b11101;
    pay = 8'h3C;
    for (int i = 4; i >= 1; i--) send_bit(pre[i], 1'b0);
    checks++;
    if (sync_det !== 1'b0) begin
      errors++;
      $display("[TB] FAIL slide_early: got sync=%b, want 0", sync_det);
    end
    send_bit(pre[0], 1'b0);
    checks++;
    if (sync_det !== 1'b1) begin
      errors++;
      $display("[TB] FAIL slide_sync: got sync=%b, want 1", sync_det);
    end
    for (int i = 7; i >= 0; i--) send_bit(pay[i], 1'b0);
    checks++;
    if (data_out !== 8'h3C || data_valid !== 1'b1 || frame_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL slide_word: got out=%h v=%b cnt=%0d, want 3c 1 2", data_out, data_valid, frame_cnt);
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1;
    send_frame(8'h11, 1'b0);
    checks++;
    if (data_out !== 8'h11 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: got out=%h overrun=%b, want 11 0", data_out, overrun);
    end
    send_frame(8'h22, 1'b0);
    checks++;
    if (data_out !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b1 || frame_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL b2b_overrun: got out=%h v=%b o=%b cnt=%0d, want 22 1 1 2",
               data_out, data_valid, overrun, frame_cnt);
    end
    pulse_ack();
    checks++;
    if (overrun !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_sticky: got o=%b v=%b, want 1 0", overrun, data_valid);
    end

    do_reset();
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b1);
    checks++;
    if (data_out !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b0 || frame_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL b2b_ack_same_cycle: got out=%h v=%b o=%b cnt=%0d, want 22 1 0 2",
               data_out, data_valid, overrun, frame_cnt);
    end
    pulse_ack();
  endtask

  task automatic test_abort();
    logic [3:0] sp;
    sp = 4'b1101;
    do_reset();
    en = 1'b1;
    for (int i = 3; i >= 0; i--) send_bit(sp[i], 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL abort_state: got busy=%b v=%b cnt=%0d, want 0 0 0", busy, data_valid, frame_cnt);
    end
    send_frame(8'h5A, 1'b0);
    checks++;
    if (data_out !== 8'h5A || data_valid !== 1'b1 || frame_cnt !== 8'd1 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_word: got out=%h v=%b cnt=%0d o=%b, want 5a 1 1 0",
               data_out, data_valid, frame_cnt, overrun);
    end
    pulse_ack();
  endtask

  task automatic test_strobe_gating();
    int bad;
    bad = 0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      din = ~din;
      @(negedge clk);
      if (sync_det !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL gating_idle: got %0d cycles with sync/busy high, want 0", bad);
    end
    send_bit(1'b1, 1'b0);
    checks++;
    if (sync_det !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gating_window_kept: got sync=%b busy=%b, want 1 1", sync_det, busy);
    end
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
    pulse_ack();
  endtask

  task automatic test_async_reset();
    logic [3:0] sp;
    sp = 4'b1101;
    send_frame(8'hA5, 1'b0);
    for (int i = 3; i >= 0; i--) send_bit(sp[i], 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, sync_det, busy, overrun, frame_cnt} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got out=%h v=%b s=%b b=%b o=%b cnt=%0d, want all zero",
               data_out, data_valid, sync_det, busy, overrun, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame(8'hFF, 1'b0);
    checks++;
    if (data_out !== 8'hFF || data_valid !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL post_reset_word: got out=%h v=%b cnt=%0d, want ff 1 1", data_out, data_valid, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 254; i++) send_frame(i[7:0], 1'b1);
    checks++;
    if (frame_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL wrap_max: got cnt=%0d, want 255", frame_cnt);
    end
    send_frame(8'h81, 1'b1);
    checks++;
    if (frame_cnt !== 8'd0 || data_out !== 8'h81 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_zero: got cnt=%0d out=%h o=%b, want 0 81 0", frame_cnt, data_out, overrun);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    bit_en   = 1'b0;
    din      = 1'b0;
    data_ack = 1'b0;
    test_reset();
    test_basic();
    test_sliding_sync();
    test_back_to_back();
    test_abort();
    test_strobe_gating();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
